// File: rtl/game_sequencer_pkg.sv
// Shared state encoding and frame-counter sizing for the play-state controller.
// The state values are also decoded by the VGA renderer, so they must stay stable.
package game_sequencer_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // DYING leaves on the tick that finds the counter at its last value; OVER saturates at the full count.
    function automatic logic [CNT_W-1:0] frame_limit(input state_e st,
                                                     input int die_frames,
                                                     input int over_frames);
        logic [CNT_W-1:0] limit;
        if (st == ST_OVER) begin
            limit = CNT_W'(over_frames);
        end else begin
            limit = CNT_W'(die_frames - 1);
        end
        return limit;
    endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame-tick counter with clear, saturation at a programmable limit and a terminal compare.
// Also exposes one bit of the next count so the caller can register a blink output.
module game_sequencer_frame_timer
    import game_sequencer_pkg::*;
#(
    parameter int FLAG_BIT = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_at_limit,
    output logic             o_flag_nxt
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    assign o_at_limit = (r_count == i_limit);

    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = '0;
        end else if (i_tick && !o_at_limit) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    assign o_flag_nxt = w_count_nxt[FLAG_BIT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Play-state controller for the flappy/bar game: start, play, death pause, lives, game over.
// Gates bar scrolling, pulses the player reset and keeps lives and the high score.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int DIE_FRAMES  = 90,
    parameter int OVER_FRAMES = 60,
    parameter int FLASH_SHIFT = 3,
    parameter int SCORE_W     = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_flap,
    input  logic               collision,
    input  logic [SCORE_W-1:0] points,
    output logic [STATE_W-1:0] state,
    output logic               scroll_en,
    output logic               player_rst,
    output logic               freeze,
    output logic               flash,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] high_score
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_btn_q;
    logic [1:0]         r_lives;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_scroll_en;
    logic               r_player_rst;
    logic               r_freeze;
    logic               r_flash;

    logic               w_btn_rise;
    logic               w_death;
    logic               w_timer_clr;
    logic               w_at_limit;
    logic               w_flag_nxt;
    logic [CNT_W-1:0]   w_limit;
    logic               w_scroll_nxt;
    logic               w_prst_nxt;
    logic               w_freeze_nxt;
    logic               w_flash_nxt;

    assign w_btn_rise = btn_flap & ~r_btn_q;
    assign w_death    = (r_state == ST_PLAY) && collision;
    assign w_limit    = frame_limit(r_state, DIE_FRAMES, OVER_FRAMES);

    // The counter only means something inside DYING/OVER, and every state change restarts it.
    assign w_timer_clr = (r_state == ST_IDLE) || (r_state == ST_PLAY) || (w_state_nxt != r_state);

    game_sequencer_frame_timer #(
        .FLAG_BIT (FLASH_SHIFT)
    ) u_frame_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_clear    (w_timer_clr),
        .i_tick     (frame_tick),
        .i_limit    (w_limit),
        .o_at_limit (w_at_limit),
        .o_flag_nxt (w_flag_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_btn_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_btn_q <= btn_flap;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_rise) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    w_state_nxt = ST_DYING;
                end
            end
            ST_DYING: begin
                if (frame_tick && w_at_limit) begin
                    w_state_nxt = (r_lives == 2'd0) ? ST_OVER : ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_btn_rise && w_at_limit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so the registered copies line up with it.
    always_comb begin
        w_scroll_nxt = (r_state == ST_PLAY) && frame_tick && !collision;
        w_prst_nxt   = (r_state != ST_PLAY) && (w_state_nxt == ST_PLAY);
        w_freeze_nxt = (w_state_nxt != ST_PLAY);
        w_flash_nxt  = (w_state_nxt == ST_DYING) && w_flag_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scroll_en  <= 1'b0;
            r_player_rst <= 1'b0;
            r_freeze     <= 1'b1;
            r_flash      <= 1'b0;
        end else begin
            r_scroll_en  <= w_scroll_nxt;
            r_player_rst <= w_prst_nxt;
            r_freeze     <= w_freeze_nxt;
            r_flash      <= w_flash_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lives      <= LIVES_INIT;
            r_high_score <= '0;
        end else if ((r_state == ST_IDLE) && w_btn_rise) begin
            r_lives <= LIVES_INIT;
        end else if (w_death) begin
            if (r_lives != 2'd0) begin
                r_lives <= r_lives - 2'd1;
            end
            if (points > r_high_score) begin
                r_high_score <= points;
            end
        end
    end

    assign state      = r_state;
    assign scroll_en  = r_scroll_en;
    assign player_rst = r_player_rst;
    assign freeze     = r_freeze;
    assign flash      = r_flash;
    assign lives      = r_lives;
    assign high_score = r_high_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a rule-level game model queues the expected outputs
// every clock and a monitor compares them with the DUT on the falling edge.
module tb_game_sequencer;

    localparam int LIVES       = 3;
    localparam int DIE_FRAMES  = 90;
    localparam int OVER_FRAMES = 60;
    localparam int FLASH_SHIFT = 3;
    localparam int SCORE_W     = 10;

    typedef struct packed {
        logic [1:0]         st;
        logic               sc;
        logic               pr;
        logic               fz;
        logic               fl;
        logic [1:0]         lv;
        logic [SCORE_W-1:0] hs;
    } snap_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               frame_tick = 1'b0;
    logic               btn_flap = 1'b0;
    logic               collision = 1'b0;
    logic [SCORE_W-1:0] points = '0;
    logic [1:0]         state;
    logic               scroll_en;
    logic               player_rst;
    logic               freeze;
    logic               flash;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] high_score;

    int    checkCount = 0;
    int    passCount  = 0;
    snap_t expQ[$];

    // Model of the game in plain terms: 0 idle, 1 play, 2 dying, 3 over.
    int mMode  = 0;
    int mLives = LIVES;
    int mHs    = 0;
    int mTicks = 0;
    bit mPrev  = 1'b0;

    game_sequencer #(
        .LIVES       (LIVES),
        .DIE_FRAMES  (DIE_FRAMES),
        .OVER_FRAMES (OVER_FRAMES),
        .FLASH_SHIFT (FLASH_SHIFT),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_flap   (btn_flap),
        .collision  (collision),
        .points     (points),
        .state      (state),
        .scroll_en  (scroll_en),
        .player_rst (player_rst),
        .freeze     (freeze),
        .flash      (flash),
        .lives      (lives),
        .high_score (high_score)
    );

    always #5 clk = ~clk;

    function automatic snap_t makeSnap(input int st, input bit sc, input bit pr, input bit fz,
                                       input bit fl, input int lv, input int hs);
        snap_t s;
        s.st = 2'(st);
        s.sc = sc;
        s.pr = pr;
        s.fz = fz;
        s.fl = fl;
        s.lv = 2'(lv);
        s.hs = SCORE_W'(hs);
        return s;
    endfunction

    function automatic snap_t modelSnap(input bit sc, input bit pr);
        bit fl;
        fl = (mMode == 2) && (((mTicks / (1 << FLASH_SHIFT)) % 2) == 1);
        return makeSnap(mMode, sc, pr, mMode != 1, fl, mLives, mHs);
    endfunction

    task automatic resetModel();
        mMode  = 0;
        mLives = LIVES;
        mHs    = 0;
        mTicks = 0;
        mPrev  = 1'b0;
    endtask

    task automatic modelStep();
        bit rise;
        bit sc;
        bit pr;
        sc   = 1'b0;
        pr   = 1'b0;
        rise = btn_flap && !mPrev;
        mPrev = btn_flap;
        case (mMode)
            0: if (rise) begin
                mMode  = 1;
                pr     = 1'b1;
                mLives = LIVES;
            end
            1: if (collision) begin
                mMode = 2;
                if (mLives > 0) mLives = mLives - 1;
                if (int'(points) > mHs) mHs = int'(points);
                mTicks = 0;
            end else if (frame_tick) begin
                sc = 1'b1;
            end
            2: if (frame_tick) begin
                if (mTicks == DIE_FRAMES - 1) begin
                    mTicks = 0;
                    if (mLives == 0) begin
                        mMode = 3;
                    end else begin
                        mMode = 1;
                        pr    = 1'b1;
                    end
                end else begin
                    mTicks = mTicks + 1;
                end
            end
            default: begin
                if (rise && mTicks >= OVER_FRAMES) begin
                    mMode  = 0;
                    mTicks = 0;
                end else if (frame_tick && mTicks < OVER_FRAMES) begin
                    mTicks = mTicks + 1;
                end
            end
        endcase
        expQ.push_back(modelSnap(sc, pr));
    endtask

    always @(negedge reset) resetModel();

    always @(posedge clk) begin
        if (!reset) begin
            resetModel();
            expQ.push_back(modelSnap(1'b0, 1'b0));
        end else begin
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input snap_t want);
        snap_t got;
        got.st = state;
        got.sc = scroll_en;
        got.pr = player_rst;
        got.fz = freeze;
        got.fl = flash;
        got.lv = lives;
        got.hs = high_score;
        checkCount++;
        if (got === want) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s t=%0t got st=%0d sc=%0b pr=%0b fz=%0b fl=%0b lv=%0d hs=%0d want st=%0d sc=%0b pr=%0b fz=%0b fl=%0b lv=%0d hs=%0d",
                     name, $time, got.st, got.sc, got.pr, got.fz, got.fl, got.lv, got.hs,
                     want.st, want.sc, want.pr, want.fz, want.fl, want.lv, want.hs);
        end
    endtask

    task automatic expectNow(input string name, input int st, input bit sc, input bit pr,
                             input bit fz, input bit fl, input int lv, input int hs);
        checkOutput(name, makeSnap(st, sc, pr, fz, fl, lv, hs));
    endtask

    // Monitor: every queued expectation is matched against the DUT on the following falling edge.
    always @(negedge clk) begin
        snap_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("scoreboard", e);
        end
    end

    task automatic applyStimulus(input bit b, input bit c, input bit t, input int p);
        @(negedge clk);
        btn_flap   = b;
        collision  = c;
        frame_tick = t;
        points     = SCORE_W'(p);
    endtask

    task automatic runFrames(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (noise) begin
                    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  k == 0, int'($urandom_range(0, 1023)));
                end else begin
                    applyStimulus(1'b0, 1'b0, k == 0, 0);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expectNow("reset_values", 0, 0, 0, 1, 0, 3, 0);
        reset = 1'b1;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        expectNow("start_play", 1, 0, 1, 0, 0, 3, 0);
        applyStimulus(1, 0, 0, 0);
        expectNow("player_rst_one_clk", 1, 0, 0, 0, 0, 3, 0);
        applyStimulus(0, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
            expectNow("scroll_pulse", 1, 1, 0, 0, 0, 3, 0);
            applyStimulus(0, 0, 0, 0);
            expectNow("scroll_one_clk", 1, 0, 0, 0, 0, 3, 0);
        end

        applyStimulus(0, 1, 0, 42);
        applyStimulus(0, 0, 0, 42);
        expectNow("first_death", 2, 0, 0, 1, 0, 2, 42);
        runFrames(7, 1);
        expectNow("flash_before_8", 2, 0, 0, 1, 0, 2, 42);
        runFrames(1, 1);
        expectNow("flash_at_8", 2, 0, 0, 1, 1, 2, 42);
        runFrames(81, 1);
        expectNow("dying_after_89", 2, 0, 0, 1, 1, 2, 42);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        expectNow("respawn_90", 1, 0, 1, 0, 0, 2, 42);

        runFrames(2, 0);
        applyStimulus(0, 1, 0, 17);
        applyStimulus(0, 0, 0, 0);
        expectNow("lower_score_kept", 2, 0, 0, 1, 0, 1, 42);
        runFrames(89, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        expectNow("respawn_second", 1, 0, 1, 0, 0, 1, 42);

        applyStimulus(0, 1, 1, 5);
        applyStimulus(0, 0, 0, 0);
        expectNow("collision_beats_tick", 2, 0, 0, 1, 0, 0, 42);
        runFrames(89, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        expectNow("game_over", 3, 0, 0, 1, 0, 0, 42);

        runFrames(30, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        expectNow("early_btn_ignored", 3, 0, 0, 1, 0, 0, 42);
        runFrames(40, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        expectNow("restart_to_idle", 0, 0, 0, 1, 0, 0, 42);

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        expectNow("new_game", 1, 0, 1, 0, 0, 3, 42);
        applyStimulus(0, 1, 0, 50);
        applyStimulus(0, 0, 0, 0);
        expectNow("new_high", 2, 0, 0, 1, 0, 2, 50);
        runFrames(12, 0);
        expectNow("flash_pre_reset", 2, 0, 0, 1, 1, 2, 50);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 expectNow("async_reset", 0, 0, 0, 1, 0, 3, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(0, 2999) == 0) begin
                @(negedge clk);
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            applyStimulus(($urandom_range(0, 5) == 0) ? !btn_flap : btn_flap,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 1023)));
        end

        repeat (3) applyStimulus(0, 0, 0, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
